// File: rtl/four_way_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter
// that drives the select pins of a shared four-to-one mux.
interface four_way_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic       s1;
    logic       s0;
    logic       busy;

    modport master (output req, input grant, input s1, input s0, input busy);
    modport slave  (input req, output grant, output s1, output s0, output busy);
endinterface

// File: rtl/four_way_rr_arbiter.sv
// Four-way round-robin arbiter with a bounded hold time per grant and a
// mandatory idle turnaround cycle between grants; all outputs registered.
module four_way_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    four_way_rr_arbiter_if.slave  bus
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     r_state;
    state_t     w_stateNext;
    logic [3:0] r_grant;
    logic [3:0] w_grantNext;
    logic [1:0] r_sel;
    logic [1:0] w_selNext;
    logic [1:0] r_last;
    logic [1:0] w_lastNext;
    logic       r_busy;
    logic       w_busyNext;
    logic [7:0] r_holdCnt;
    logic [7:0] w_holdCntNext;
    logic [1:0] w_pickIdx;
    logic       w_pickValid;
    logic [1:0] w_cand;

    // Scan from farthest to nearest so the requester closest after r_last wins.
    always_comb begin
        w_pickIdx   = r_last;
        w_pickValid = 1'b0;
        w_cand      = r_last;
        for (int k = 4; k >= 1; k--) begin
            w_cand = r_last + 2'(k);
            if (bus.req[w_cand]) begin
                w_pickIdx   = w_cand;
                w_pickValid = 1'b1;
            end
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_grantNext   = r_grant;
        w_selNext     = r_sel;
        w_lastNext    = r_last;
        w_busyNext    = r_busy;
        w_holdCntNext = r_holdCnt;
        case (r_state)
            IDLE: begin
                w_grantNext   = 4'b0000;
                w_busyNext    = 1'b0;
                w_holdCntNext = 8'd0;
                if (w_pickValid) begin
                    w_stateNext = GRANT;
                    w_grantNext = 4'b0001 << w_pickIdx;
                    w_selNext   = w_pickIdx;
                    w_busyNext  = 1'b1;
                    w_lastNext  = w_pickIdx;
                end
            end
            GRANT: begin
                // Select lines keep their value on release so the mux never glitches.
                if (!bus.req[r_last] || (r_holdCnt == HOLD_LIMIT)) begin
                    w_stateNext   = IDLE;
                    w_grantNext   = 4'b0000;
                    w_busyNext    = 1'b0;
                    w_holdCntNext = 8'd0;
                end else begin
                    w_holdCntNext = r_holdCnt + 8'd1;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_grant   <= 4'b0000;
            r_sel     <= 2'b00;
            r_last    <= 2'd3;
            r_busy    <= 1'b0;
            r_holdCnt <= 8'd0;
        end else begin
            r_state   <= w_stateNext;
            r_grant   <= w_grantNext;
            r_sel     <= w_selNext;
            r_last    <= w_lastNext;
            r_busy    <= w_busyNext;
            r_holdCnt <= w_holdCntNext;
        end
    end

    assign bus.grant = r_grant;
    assign bus.s1    = r_sel[1];
    assign bus.s0    = r_sel[0];
    assign bus.busy  = r_busy;

endmodule
